pixel_raster_tx: RTL and testbench
==================================

# pixel_raster_tx

Transmit side of the raster pixel stream consumed by the windowing blocks. Accepts a plain ready/valid pixel stream from a frame source (memory reader, camera adapter, test pattern). Emits the tagged stream `data_o`/`col_o`/`row_o`/`valid_o` in raster order, optionally inserting line and frame blanking. The output has no backpressure; downstream blocks sample every cycle that `valid_o` is high.

## Interface

- `DATA_WIDTH`, 8: pixel width in bits.
- `IMAGE_WIDTH`, 640: pixels per line; must be ≥ 2.
- `IMAGE_HEIGHT`, 480: lines per frame; must be ≥ 2.
- `H_BLANK`, 0: idle cycles inserted after each non-final line; range 0..65535.
- `V_BLANK`, 0: idle cycles inserted after the final line; range 0..65535.
- `CONTINUOUS`, 0: 1 means a new frame starts automatically after the frame blank; 0 means return to IDLE.
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, asynchronous assert, active-low.
- `start_i` in 1: begin a frame; honoured only in IDLE.
- `abort_i` in 1: synchronous abort back to IDLE; takes priority over all other inputs.
- `in_data_i` in DATA_WIDTH: upstream pixel.
- `in_valid_i` in 1: upstream pixel valid.
- `in_ready_o` out 1: block can accept a pixel.
- `data_o` out DATA_WIDTH: tagged pixel.
- `col_o` out 16: column of `data_o`.
- `row_o` out 16: row of `data_o`.
- `valid_o` out 1: output beat valid.
- `sof_o` out 1: qualifies the beat at (0,0).
- `eof_o` out 1: qualifies the beat at (IMAGE_WIDTH-1, IMAGE_HEIGHT-1).
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation

- States and transitions:
  - IDLE → ACTIVE on `start_i`.
  - In ACTIVE, an accept at col W-1 of a non-final row goes to HBLANK if `H_BLANK` > 0, otherwise stays in ACTIVE.
  - In ACTIVE, an accept at (W-1, H-1) goes to VBLANK if `V_BLANK` > 0. Otherwise it goes to the end-of-frame target.
  - HBLANK → ACTIVE after exactly `H_BLANK` cycles.
  - VBLANK → end-of-frame target after exactly `V_BLANK` cycles.
  - End-of-frame target: ACTIVE with counters at (0,0) if `CONTINUOUS`, otherwise IDLE.
- `in_ready_o` = (state == ACTIVE) && !`abort_i`. It is a combinational function of state and `abort_i` only, never of `in_valid_i`.
- Accept = `in_valid_i` && `in_ready_o`. The col/row counters advance only on accept.
  - col wraps from W-1 to 0 and increments row.
  - row wraps from H-1 to 0.
- Output stage is registered:
  - `valid_o` <= accept.
  - `data_o`, `col_o`, `row_o` <= the input pixel and the pre-increment counters, on accept only; otherwise they hold.
  - `sof_o` and `eof_o` are registered alongside and are low whenever `valid_o` is low.
- Upstream stalls (`in_valid_i` low while in ACTIVE) produce `valid_o` gaps of equal length. The counters and the blank counter are unaffected.
- `start_i` outside IDLE is ignored. `start_i` and `abort_i` together in IDLE: abort wins and the block stays IDLE.
- `abort_i`:
  - Next state is IDLE; counters and the blank counter are cleared.
  - The pixel presented that cycle is not accepted; the next-cycle `valid_o` is 0.
  - The partial frame is abandoned; the next `start_i` restarts at (0,0).
- Counters are 16 bits; IMAGE_WIDTH and IMAGE_HEIGHT ≤ 65535. The blank counter counts down from N-1 to 0.

## Timing

- Reset (async assert, release synchronous to `clk_i`):
  - State IDLE; counters 0.
  - `in_ready_o`, `valid_o`, `sof_o`, `eof_o`, `busy_o` = 0.
  - `data_o`, `col_o`, `row_o` = 0.
- Latency: accept in cycle t → `valid_o` in cycle t+1.
- `start_i` in cycle t → `in_ready_o` high in cycle t+1.
- Maximum throughput is 1 pixel per cycle in ACTIVE.
- After the accept at col W-1, `in_ready_o` is low for exactly `H_BLANK` cycles.
- After the accept at (W-1, H-1), `in_ready_o` is low for exactly `V_BLANK` cycles.
- `abort_i` in cycle t → `busy_o` low in cycle t+1.

## Configuration

- `PIXEL_RASTER_TX_BLANK_EN` defined:
  - HBLANK/VBLANK states and the blank counter are present, with behaviour as above.
- Not defined:
  - Blank states and the blank counter are not built; `H_BLANK` and `V_BLANK` are ignored.
  - Line wrap stays in ACTIVE.
  - Frame end goes directly to the end-of-frame target, so back-to-back frames with `CONTINUOUS` have zero gap.

## Structure

- Shared package `pixel_stream_pkg`:
  - `coord_t` (logic [15:0]), `COORD_WIDTH` = 16.
  - `raster_tx_state_t` enum {IDLE, ACTIVE, HBLANK, VBLANK}.
- Sub-module `raster_counter`:
  - col/row counter with `inc_i`, `clr_i`, `col_o`, `row_o`, `eol_o`, `eof_o`.
  - Parameterised by IMAGE_WIDTH and IMAGE_HEIGHT.
  - Designed so it can be reused by downstream stream blocks.

## Test plan

All scenarios use W=4, H=3.

- Reset, then `start_i` with `in_valid_i` held high → 12 beats (0,0)..(3,2) in consecutive cycles, the first one cycle after the first accept. `sof_o` is high on (0,0) only and `eof_o` on (3,2) only. IDLE follows and `busy_o` drops.
- Macro defined, H_BLANK=2, V_BLANK=3 → `in_ready_o` is low for exactly 2 cycles after the (3,0) and (3,1) accepts, and for 3 cycles after (3,2), then IDLE.
- `in_valid_i` low for 5 cycles after the (1,1) accept → `valid_o` low for 5 cycles, next beat (2,1), counters intact.
- `abort_i` on the cycle (2,1) is presented → (2,1) is not output, `busy_o`=0 and `in_ready_o`=0 next cycle. A later `start_i` yields (0,0) first.
- CONTINUOUS=1, V_BLANK=3 → the second frame starts at (0,0) after 3 idle cycles without `start_i`. `start_i` pulsed mid-frame has no effect.
- Macro undefined with H_BLANK=2 → all 12 pixels are accepted in 12 consecutive cycles with no gaps.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pixel_stream_pkg                                           |
// | Purpose : Shared types for the raster pixel stream blocks            |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package pixel_stream_pkg;

  localparam int COORD_WIDTH = 16;

  typedef logic [COORD_WIDTH-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } raster_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_raster_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pixel_raster_tx_if                                         |
// | Purpose : Upstream ready/valid pixels plus the tagged raster output  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface pixel_raster_tx_if #(
  parameter int DATA_WIDTH = 8
);
  import pixel_stream_pkg::*;

  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] data_o;
  coord_t                col_o;
  coord_t                row_o;
  logic                  valid_o;
  logic                  sof_o;
  logic                  eof_o;

  // The transmitter side: consumes pixels, produces the tagged stream
  modport slave (
    input  in_data_i, in_valid_i,
    output in_ready_o, data_o, col_o, row_o, valid_o, sof_o, eof_o
  );

  // The frame source / stream consumer side
  modport master (
    output in_data_i, in_valid_i,
    input  in_ready_o, data_o, col_o, row_o, valid_o, sof_o, eof_o
  );

endinterface
`default_nettype wire

// File: rtl/pixel_raster_tx_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : raster_counter                                             |
// | Purpose : Reusable col/row raster position counter with wrap flags   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module raster_counter
  import pixel_stream_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   inc_i,
  input  logic   clr_i,
  output coord_t col_o,
  output coord_t row_o,
  output logic   eol_o,
  output logic   eof_o
);

  localparam coord_t C_COL_LAST = coord_t'(IMAGE_WIDTH - 1);
  localparam coord_t C_ROW_LAST = coord_t'(IMAGE_HEIGHT - 1);

  coord_t r_col;
  coord_t r_row;

  assign col_o = r_col;
  assign row_o = r_row;
  assign eol_o = (r_col == C_COL_LAST);
  assign eof_o = (r_col == C_COL_LAST) && (r_row == C_ROW_LAST);

  // Advance in raster order; clear wins over increment
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clr_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (inc_i) begin
      if (eol_o) begin
        r_col <= '0;
        r_row <= eof_o ? '0 : r_row + coord_t'(1);
      end else begin
        r_col <= r_col + coord_t'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_raster_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pixel_raster_tx                                            |
// | Purpose : Ready/valid pixels in, tagged raster stream out, with      |
// |           optional line/frame blanking (PIXEL_RASTER_TX_BLANK_EN)    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pixel_raster_tx
  import pixel_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int H_BLANK      = 0,
  parameter int V_BLANK      = 0,
  parameter int CONTINUOUS   = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  pixel_raster_tx_if.slave stream
);

  // Where a completed frame lands: straight into the next one, or idle
  localparam raster_tx_state_t C_EOF_TARGET = (CONTINUOUS != 0) ? ACTIVE : IDLE;

  raster_tx_state_t      r_state;
  logic [DATA_WIDTH-1:0] r_data;
  coord_t                r_col;
  coord_t                r_row;
  logic                  r_valid;
  logic                  r_sof;
  logic                  r_eof;

  coord_t w_col;
  coord_t w_row;
  logic   w_eol;
  logic   w_eof;
  logic   w_ready;
  logic   w_accept;

`ifdef PIXEL_RASTER_TX_BLANK_EN
  // Blank counter loads N-1 so the blank state lasts exactly N cycles
  localparam coord_t C_HB_LOAD = coord_t'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam coord_t C_VB_LOAD = coord_t'((V_BLANK > 0) ? V_BLANK - 1 : 0);
  coord_t r_blank;
`else
  logic w_unused_blank_cfg;
  assign w_unused_blank_cfg = ^{32'(H_BLANK), 32'(V_BLANK)};
`endif

  // Ready depends only on state and abort, never on upstream valid
  assign w_ready          = (r_state == ACTIVE) && !abort_i;
  assign w_accept         = stream.in_valid_i && w_ready;
  assign stream.in_ready_o = w_ready;
  assign busy_o           = (r_state != IDLE);

  assign stream.data_o  = r_data;
  assign stream.col_o   = r_col;
  assign stream.row_o   = r_row;
  assign stream.valid_o = r_valid;
  assign stream.sof_o   = r_sof;
  assign stream.eof_o   = r_eof;

  raster_counter #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT)
  ) u_counter (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (w_accept),
    .clr_i   (abort_i),
    .col_o   (w_col),
    .row_o   (w_row),
    .eol_o   (w_eol),
    .eof_o   (w_eof)
  );

  // Frame sequencing: idle / active / line blank / frame blank
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
`ifdef PIXEL_RASTER_TX_BLANK_EN
      r_blank <= '0;
`endif
    end else if (abort_i) begin
      r_state <= IDLE;
`ifdef PIXEL_RASTER_TX_BLANK_EN
      r_blank <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) r_state <= ACTIVE;
        end
        ACTIVE: begin
          if (w_accept && w_eol) begin
`ifdef PIXEL_RASTER_TX_BLANK_EN
            if (w_eof) begin
              if (V_BLANK > 0) begin
                r_state <= VBLANK;
                r_blank <= C_VB_LOAD;
              end else begin
                r_state <= C_EOF_TARGET;
              end
            end else if (H_BLANK > 0) begin
              r_state <= HBLANK;
              r_blank <= C_HB_LOAD;
            end
`else
            if (w_eof) r_state <= C_EOF_TARGET;
`endif
          end
        end
`ifdef PIXEL_RASTER_TX_BLANK_EN
        HBLANK: begin
          if (r_blank == '0) r_state <= ACTIVE;
          else               r_blank <= r_blank - coord_t'(1);
        end
        VBLANK: begin
          if (r_blank == '0) r_state <= C_EOF_TARGET;
          else               r_blank <= r_blank - coord_t'(1);
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  // Registered output beat; payload holds between beats
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_data  <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_valid <= w_accept;
      r_sof   <= w_accept && (w_col == '0) && (w_row == '0);
      r_eof   <= w_accept && w_eof;
      if (w_accept) begin
        r_data <= stream.in_data_i;
        r_col  <= w_col;
        r_row  <= w_row;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_raster_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_pixel_raster_tx                                         |
// | Purpose : Scoreboard bench for pixel_raster_tx, W=4 H=3              |
// |           Instance A: one-shot, H_BLANK=2 V_BLANK=3                  |
// |           Instance B: continuous, V_BLANK=3                          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_pixel_raster_tx;
  import pixel_stream_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
`ifdef PIXEL_RASTER_TX_BLANK_EN
  localparam int HB_A = 2;
  localparam int VB_A = 3;
  localparam int VB_B = 3;
`else
  localparam int HB_A = 0;
  localparam int VB_A = 0;
  localparam int VB_B = 0;
`endif
  localparam int HB_B = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
    int         r;
    bit         sof;
    bit         eof;
    int         at;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_v [2];
  logic       abort_v [2];
  logic       valid_v [2];
  logic [7:0] data_v  [2];

  logic       rdy_w  [2];
  logic       busy_w [2];
  logic       vo_w   [2];
  logic       sof_w  [2];
  logic       eof_w  [2];
  logic [7:0] dat_w  [2];
  coord_t     col_w  [2];
  coord_t     row_w  [2];

  beat_t q_a[$];
  beat_t q_b[$];

  int n_chk = 0;
  int n_pass = 0;

  pixel_raster_tx_if #(.DATA_WIDTH(8)) if_a ();
  pixel_raster_tx_if #(.DATA_WIDTH(8)) if_b ();

  assign if_a.in_valid_i = valid_v[0];
  assign if_a.in_data_i  = data_v[0];
  assign if_b.in_valid_i = valid_v[1];
  assign if_b.in_data_i  = data_v[1];

  assign rdy_w[0] = if_a.in_ready_o;  assign rdy_w[1] = if_b.in_ready_o;
  assign vo_w[0]  = if_a.valid_o;     assign vo_w[1]  = if_b.valid_o;
  assign sof_w[0] = if_a.sof_o;       assign sof_w[1] = if_b.sof_o;
  assign eof_w[0] = if_a.eof_o;       assign eof_w[1] = if_b.eof_o;
  assign dat_w[0] = if_a.data_o;      assign dat_w[1] = if_b.data_o;
  assign col_w[0] = if_a.col_o;       assign col_w[1] = if_b.col_o;
  assign row_w[0] = if_a.row_o;       assign row_w[1] = if_b.row_o;

  pixel_raster_tx #(
    .DATA_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .H_BLANK(2), .V_BLANK(3), .CONTINUOUS(0)
  ) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_v[0]), .abort_i(abort_v[0]),
    .busy_o(busy_w[0]), .stream(if_a)
  );

  pixel_raster_tx #(
    .DATA_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .H_BLANK(0), .V_BLANK(3), .CONTINUOUS(1)
  ) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_v[1]), .abort_i(abort_v[1]),
    .busy_o(busy_w[1]), .stream(if_b)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic qpush(input int i, input beat_t e);
    if (i == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic qpop(input int i, output beat_t e);
    if (i == 0) e = q_a.pop_front();
    else        e = q_b.pop_front();
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q_a.size() : q_b.size();
  endfunction

  // Monitor: compare each presented beat against the scoreboard head
  task automatic mon(input int i);
    beat_t e;
    if (vo_w[i]) begin
      if (qsize(i) == 0) begin
        chk($sformatf("unexpected_beat%0d", i), 1, 0);
      end else begin
        qpop(i, e);
        chk($sformatf("beat_cycle%0d", i), cyc, e.at);
        chk($sformatf("beat_data%0d", i), dat_w[i], e.d);
        chk($sformatf("beat_col%0d", i), col_w[i], e.c);
        chk($sformatf("beat_row%0d", i), row_w[i], e.r);
        chk($sformatf("beat_sof%0d", i), sof_w[i], e.sof);
        chk($sformatf("beat_eof%0d", i), eof_w[i], e.eof);
      end
    end else begin
      if (sof_w[i] || eof_w[i]) chk($sformatf("flag_without_valid%0d", i), 1, 0);
      if (qsize(i) != 0) begin
        e = (i == 0) ? q_a[0] : q_b[0];
        if (e.at <= cyc) begin
          chk($sformatf("missing_beat%0d", i), 0, 1);
          qpop(i, e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  // Drive one frame on instance i. Negative k arguments disable the
  // stall / abort / mid-frame start features.
  task automatic frame(input int i, input bit do_start, input int stall_k,
                       input int stall_n, input int abort_k, input int start_k);
    int    hb = (i == 0) ? HB_A : HB_B;
    int    vb = (i == 0) ? VB_A : VB_B;
    bit    cont = (i == 1);
    int    k = 0;
    beat_t e;
    if (do_start) begin
      start_v[i] = 1'b1;
      @(negedge clk);
      chk("idle_ready", rdy_w[i], 0);
      @(posedge clk); #1;
      start_v[i] = 1'b0;
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        valid_v[i] = 1'b1;
        data_v[i]  = 8'(8'h40 + k * 13 + i);
        start_v[i] = (k == start_k);
        if (k == abort_k) begin
          abort_v[i] = 1'b1;
          @(negedge clk);
          chk("abort_ready", rdy_w[i], 0);
          @(posedge clk); #1;
          abort_v[i] = 1'b0;
          valid_v[i] = 1'b0;
          start_v[i] = 1'b0;
          @(negedge clk);
          chk("abort_busy", busy_w[i], 0);
          chk("abort_ready_next", rdy_w[i], 0);
          @(posedge clk); #1;
          return;
        end
        @(negedge clk);
        chk("active_ready", rdy_w[i], 1);
        e.d = data_v[i]; e.c = c; e.r = r;
        e.sof = (k == 0); e.eof = (k == W * H - 1); e.at = cyc + 1;
        qpush(i, e);
        @(posedge clk); #1;
        valid_v[i] = 1'b0;
        start_v[i] = 1'b0;
        if (k == stall_k) begin
          repeat (stall_n) begin
            @(negedge clk);
            chk("stall_ready", rdy_w[i], 1);
            @(posedge clk); #1;
          end
        end
        if (c == W - 1) begin
          int nb;
          nb = (r == H - 1) ? vb : hb;
          valid_v[i] = 1'b1;
          repeat (nb) begin
            @(negedge clk);
            chk("blank_ready", rdy_w[i], 0);
            chk("blank_busy", busy_w[i], 1);
            @(posedge clk); #1;
          end
          valid_v[i] = 1'b0;
        end
        k++;
      end
    end
    if (!cont) begin
      @(negedge clk);
      chk("end_busy", busy_w[i], 0);
      chk("end_ready", rdy_w[i], 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; abort_v[i] = 1'b0; valid_v[i] = 1'b0; data_v[i] = 8'h00;
    end

    // Reset values on both instances
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", rdy_w[i], 0);
      chk("rst_valid", vo_w[i], 0);
      chk("rst_sof", sof_w[i], 0);
      chk("rst_eof", eof_w[i], 0);
      chk("rst_busy", busy_w[i], 0);
      chk("rst_data", dat_w[i], 0);
      chk("rst_col", col_w[i], 0);
      chk("rst_row", row_w[i], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full frame with valid held high
    frame(0, 1'b1, -1, 0, -1, -1);
    chk("hold_col", col_w[0], W - 1);
    chk("hold_row", row_w[0], H - 1);
    chk("hold_data", dat_w[0], 8'(8'h40 + 11 * 13));

    // start and abort together in IDLE: stays idle
    start_v[0] = 1'b1; abort_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0; abort_v[0] = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy_w[0], 0);
    chk("start_abort_ready", rdy_w[0], 0);
    @(posedge clk); #1;

    // Five-cycle upstream stall after the (1,1) accept
    frame(0, 1'b1, 5, 5, -1, -1);

    // Abort when (2,1) is presented, then a clean restart from (0,0)
    frame(0, 1'b1, -1, 0, 6, -1);
    frame(0, 1'b1, -1, 0, -1, -1);

    // Continuous instance: second frame self-starts, mid-frame start ignored
    frame(1, 1'b1, -1, 0, -1, -1);
    frame(1, 1'b0, -1, 0, -1, 5);
    frame(1, 1'b0, -1, 0, 0, -1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
